// File: rtl/poly_voice_allocator.sv
// poly_voice_allocator: assigns decoded MIDI voice events to synth voices with
// per-channel sustain, same-note retrigger, release-aware allocation and stealing.
module poly_voice_allocator #(
  parameter int VOICES    = 8,
  parameter int V_WIDTH   = 3,
  parameter int CHANNELS  = 16,
  parameter int CH_WIDTH  = 4,
  parameter int AGE_WIDTH = 8,
  parameter int STEAL_EN  = 1
) (
  input  logic                data_clk,
  input  logic                reset_reg_N,
  input  logic                ev_valid,
  output logic                ev_ready,
  input  logic [1:0]          ev_type,
  input  logic [CH_WIDTH-1:0] ev_chan,
  input  logic [6:0]          ev_note,
  input  logic [6:0]          ev_vel,
  input  logic [VOICES-1:0]   voice_free,
  output logic [VOICES-1:0]   key_on,
  output logic                upd_valid,
  output logic [V_WIDTH-1:0]  upd_voice,
  output logic [6:0]          upd_note,
  output logic [6:0]          upd_vel,
  output logic                upd_gate,
  output logic                upd_steal,
  output logic                drop_pulse,
  output logic [V_WIDTH:0]    active_voices
);
  localparam logic [1:0] V_FREE = 2'd0, V_HELD = 2'd1, V_SUS = 2'd2, V_REL = 2'd3;
  localparam logic [V_WIDTH:0] NV = (V_WIDTH+1)'(VOICES);
  typedef enum logic [1:0] {IDLE, SEARCH, APPLY, SWEEP} state_t;
  state_t state, nstate;
  logic [1:0] vst [VOICES];
  logic [AGE_WIDTH-1:0] age [VOICES];
  logic [6:0] vnote [VOICES];
  logic [CH_WIDTH-1:0] vch [VOICES];
  logic [CHANNELS-1:0] sus;
  logic [1:0] e_type;
  logic [CH_WIDTH-1:0] e_ch;
  logic [6:0] e_note, e_vel;
  logic [VOICES-1:0] vf_q;
  logic [V_WIDTH:0] sw_idx;
  logic [V_WIDTH-1:0] m_idx, o_idx, f_idx, r_idx, s_idx, a_idx, sw_v;
  logic [AGE_WIDTH-1:0] r_age, s_age;
  logic m_hit, o_hit, f_hit, r_hit, s_hit, a_hit, a_steal;
  logic note_on, note_off, sweep_ev, sw_act, sw_match;
  // Priority search over voices; strict '>' keeps age ties on the lowest index
  always_comb begin
    m_hit = 1'b0; o_hit = 1'b0; f_hit = 1'b0; r_hit = 1'b0; s_hit = 1'b0;
    m_idx = '0; o_idx = '0; f_idx = '0; r_idx = '0; s_idx = '0;
    r_age = '0; s_age = '0;
    for (int i = 0; i < VOICES; i++) begin
      if (!m_hit && (vst[i] == V_HELD || vst[i] == V_SUS) && vch[i] == e_ch && vnote[i] == e_note) begin
        m_hit = 1'b1; m_idx = V_WIDTH'(i);
      end
      if (!o_hit && vst[i] == V_HELD && vch[i] == e_ch && vnote[i] == e_note) begin
        o_hit = 1'b1; o_idx = V_WIDTH'(i);
      end
      if (!f_hit && vst[i] == V_FREE) begin
        f_hit = 1'b1; f_idx = V_WIDTH'(i);
      end
      if (vst[i] == V_REL && (!r_hit || age[i] > r_age)) begin
        r_hit = 1'b1; r_idx = V_WIDTH'(i); r_age = age[i];
      end
      if ((vst[i] == V_HELD || vst[i] == V_SUS) && (!s_hit || age[i] > s_age)) begin
        s_hit = 1'b1; s_idx = V_WIDTH'(i); s_age = age[i];
      end
    end
  end
  always_comb begin
    note_on  = e_type == 2'd1 && e_vel != 7'd0;
    note_off = e_type == 2'd0 || (e_type == 2'd1 && e_vel == 7'd0);
    sweep_ev = e_type == 2'd3 || (e_type == 2'd2 && !e_vel[6]);
    a_hit    = m_hit || f_hit || r_hit || (s_hit && STEAL_EN != 0);
    a_idx    = m_hit ? m_idx : f_hit ? f_idx : r_hit ? r_idx : s_idx;
    a_steal  = !(m_hit || f_hit || r_hit);
    sw_v     = state == APPLY ? '0 : sw_idx[V_WIDTH-1:0];
    sw_act   = (state == APPLY && sweep_ev) || (state == SWEEP && sw_idx != NV);
    sw_match = e_type == 2'd3 ? (vst[sw_v] == V_HELD || vst[sw_v] == V_SUS)
                              : (vst[sw_v] == V_SUS && vch[sw_v] == e_ch);
    active_voices = '0;
    for (int i = 0; i < VOICES; i++) active_voices = active_voices + (V_WIDTH+1)'(key_on[i]);
  end
  always_ff @(posedge data_clk or negedge reset_reg_N)
    if (!reset_reg_N) state <= IDLE;
    else state <= nstate;
  always_comb
    nstate = state == IDLE   ? (ev_valid ? SEARCH : IDLE) :
             state == SEARCH ? APPLY :
             state == APPLY  ? (sweep_ev ? SWEEP : IDLE) :
                               (sw_idx == NV ? IDLE : SWEEP);
  always_comb ev_ready = state == IDLE;
  // Decisions commit at the end of SEARCH so the strobe and key_on appear together in APPLY
  always_ff @(posedge data_clk or negedge reset_reg_N)
    if (!reset_reg_N) begin
      for (int i = 0; i < VOICES; i++) begin
        vst[i] <= V_FREE; age[i] <= '0; vnote[i] <= '0; vch[i] <= '0;
      end
      sus <= '0; e_type <= '0; e_ch <= '0; e_note <= '0; e_vel <= '0;
      vf_q <= '0; sw_idx <= '0; key_on <= '0;
      upd_valid <= 1'b0; upd_voice <= '0; upd_note <= '0; upd_vel <= '0;
      upd_gate <= 1'b0; upd_steal <= 1'b0; drop_pulse <= 1'b0;
    end else begin
      vf_q <= voice_free;
      upd_valid <= 1'b0;
      upd_steal <= 1'b0;
      drop_pulse <= 1'b0;
      for (int i = 0; i < VOICES; i++)
        if (vst[i] == V_REL && vf_q[i]) vst[i] <= V_FREE;
      if (ev_valid && ev_ready) begin
        e_type <= ev_type; e_ch <= ev_chan; e_note <= ev_note; e_vel <= ev_vel;
      end
      if (state == SEARCH) begin
        if (note_on) begin
          for (int i = 0; i < VOICES; i++) age[i] <= &age[i] ? age[i] : age[i] + 1'b1;
          if (a_hit) begin
            vst[a_idx] <= V_HELD; age[a_idx] <= '0; vnote[a_idx] <= e_note; vch[a_idx] <= e_ch;
            key_on[a_idx] <= 1'b1;
            upd_valid <= 1'b1; upd_voice <= a_idx; upd_note <= e_note; upd_vel <= e_vel;
            upd_gate <= 1'b1; upd_steal <= a_steal;
          end else drop_pulse <= 1'b1;
        end else if (note_off && o_hit) begin
          if (sus[e_ch]) vst[o_idx] <= V_SUS;
          else begin
            vst[o_idx] <= V_REL; key_on[o_idx] <= 1'b0;
            upd_valid <= 1'b1; upd_voice <= o_idx; upd_note <= vnote[o_idx]; upd_vel <= e_vel;
            upd_gate <= 1'b0;
          end
        end else if (e_type == 2'd2) sus[e_ch] <= e_vel[6];
      end
      if (state == APPLY) sw_idx <= (V_WIDTH+1)'(1);
      else if (state == SWEEP) sw_idx <= sw_idx + 1'b1;
      if (sw_act && sw_match) begin
        vst[sw_v] <= V_REL; key_on[sw_v] <= 1'b0;
        upd_valid <= 1'b1; upd_voice <= sw_v; upd_note <= vnote[sw_v]; upd_vel <= '0;
        upd_gate <= 1'b0;
      end
    end
endmodule

// File: doc/poly_voice_allocator.md
Name: poly_voice_allocator

Overview:
- Multi-channel successor to the single-channel note stack.
- Receives decoded MIDI voice events over a valid/ready handshake and assigns notes to VOICES synth voices.
- Supports per-channel sustain pedal, same-note retrigger, release-aware allocation and optional oldest-note stealing.
- Sits between the MIDI decoder and synth_engine; drives key_on and a per-voice update strobe.

Parameters:
- VOICES, 8, number of synth voices
- V_WIDTH, 3, log2(VOICES)
- CHANNELS, 16, MIDI channels tracked
- CH_WIDTH, 4, log2(CHANNELS)
- AGE_WIDTH, 8, per-voice saturating age counter width
- STEAL_EN, 1, 1 = steal oldest held voice when none available; 0 = drop the note

Ports:
- data_clk  in  1  system clock
- reset_reg_N  in  1  reset
- ev_valid  in  1  event present
- ev_ready  out  1  allocator accepts event
- ev_type  in  2  0 note-off, 1 note-on, 2 sustain, 3 all-notes-off
- ev_chan  in  CH_WIDTH  MIDI channel
- ev_note  in  7  note number
- ev_vel  in  7  velocity; sustain value for type 2
- voice_free  in  VOICES  envelope of voice i finished
- key_on  out  VOICES  gate per voice
- upd_valid  out  1  one-cycle update strobe
- upd_voice  out  V_WIDTH  voice being updated
- upd_note  out  7  note on that voice
- upd_vel  out  7  note-on or note-off velocity
- upd_gate  out  1  1 = gate on, 0 = gate off
- upd_steal  out  1  update is a steal
- drop_pulse  out  1  note-on discarded
- active_voices  out  V_WIDTH+1  count of HELD and SUSTAINED voices

Behaviour:
- Interface: one clock, data_clk, rising edge. Reset reset_reg_N is asynchronous, active-low.
- Reset:
  - All outputs 0; ev_ready = 1.
  - Every voice state FREE, age 0, note 0, channel 0; all sustain flags 0.
  - Assertion mid-operation aborts any sweep immediately.
- Per-voice state: FREE, HELD, SUSTAINED, RELEASING.
  - RELEASING -> FREE when registered voice_free[i] = 1.
  - voice_free is ignored in every other state.
  - If allocation of voice i and its voice_free occur in the same cycle, allocation wins.
- Controller FSM: IDLE, SEARCH, APPLY, SWEEP.
  - ev_ready = 1 only in IDLE.
  - The event latches on ev_valid & ev_ready; IDLE -> SEARCH.
  - SEARCH: one cycle, combinational priority search over voices. -> APPLY.
  - APPLY: updates state, emits at most one upd_valid, returns to IDLE. Exception: a sweep goes to SWEEP.
  - Note-on latency: accepted at cycle T, upd_valid at T+2, ev_ready high again at T+3.
- Note-on with vel = 0 is treated as note-off, with upd_vel = 0.
- Note-on allocation order:
  1. Voice HELD or SUSTAINED with the same channel and note: retrigger it, upd_gate = 1, age reset.
  2. Lowest-index FREE voice.
  3. RELEASING voice with the largest age.
  4. If STEAL_EN: HELD or SUSTAINED voice with the largest age, upd_steal = 1.
  5. Otherwise: drop_pulse for 1 cycle, no update.
  - Age ties go to the lowest index.
  - The allocated voice becomes HELD, key_on[i] = 1, age = 0.
  - All other ages saturate-increment by 1 per accepted note-on.
- Note-off: matches a HELD voice with the same channel and note.
  - If that channel's sustain is set: voice -> SUSTAINED, key_on stays 1, no update.
  - Otherwise: voice -> RELEASING, key_on = 0, upd_gate = 0.
  - No match: no update, no state change.
- Sustain (type 2):
  - ev_vel >= 64 sets the channel's sustain flag; no update.
  - ev_vel < 64 clears the flag and enters SWEEP.
- All-notes-off: enters SWEEP over all channels.
- SWEEP:
  - Index 0..VOICES-1, one voice per cycle.
  - Each SUSTAINED voice of the target channel (for all-notes-off: each HELD or SUSTAINED voice, any channel) -> RELEASING, key_on = 0, upd_valid with upd_gate = 0 and upd_vel = 0.
  - Non-matching voices produce no strobe.
  - Lasts exactly VOICES cycles, then IDLE.
- active_voices updates in the same cycle as key_on. It never exceeds VOICES and never underflows.

Test Plan:
1. Reset, then note-on ch0 note 60 vel 100 -> at T+2: upd_valid, upd_voice = 0, upd_note = 60, upd_gate = 1, key_on = 8'h01, active_voices = 1.
2. Note-on ch0 notes 60..67, then note 68 with STEAL_EN = 1 -> voice 0 (oldest) retriggered with upd_steal = 1, upd_note = 68; with STEAL_EN = 0 -> drop_pulse only, key_on stays 8'hFF.
3. Sustain ch1 vel 127, note-on/off ch1 note 50 -> key_on stays set with no off-update. Sustain ch1 vel 0 -> one upd_gate = 0 during the VOICES-cycle SWEEP, then ev_ready = 1.
4. Note-on 60, note-off 60, note-on 62 while voice 0 is RELEASING and all other voices are FREE -> voice 1 chosen. After voice_free[0] pulses, the next note goes to voice 0.
5. Note-on ch2 note 70 twice -> same voice retriggered, active_voices = 1. Note-off for unheld note 71 -> no upd_valid.
6. Four voices held, then all-notes-off -> four strobes, key_on = 0, active_voices = 0. Reset asserted mid-SWEEP -> all outputs 0 immediately.
